// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is cut
// into BLOCK-bit lookahead slices. Each pipeline stage resolves one slice and
// registers the carry into the next slice, so latency is WIDTH/BLOCK cycles
// and throughput is one result per cycle.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high; clears every stage
//   in_valid       operands presented this cycle
//   in_ready       block accepts operands this cycle (low only while stalled)
//   data_operandA  operand A
//   data_operandB  operand B
//   cin            carry-in for addition (ignored when sub=1)
//   sub            0: A+B+cin, 1: A-B
//   out_valid      result valid
//   out_ready      consumer accepts the result
//   sum            result, modulo 2^WIDTH
//   cout           carry out of the MSB (for sub, 1 = no borrow)
//   overflow       two's-complement signed overflow
//   zero           sum == 0
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / BLOCK;
    localparam int LAST   = STAGES - 1;

    // One lookahead slice. Every carry is written as a flat sum of products
    // of the slice's generate/propagate terms and the incoming carry, so no
    // carry depends on the previous bit's carry.
    // Returns {carry_out, carry_into_msb, sum_slice}.
    function automatic logic [BLOCK+1:0] cla_slice(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             c0
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             acc;
        logic             prod;
        g    = a & b;
        p    = a | b;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & c0);
        end
        return {c[BLOCK], c[BLOCK-1], a ^ b ^ c[BLOCK-1:0]};
    endfunction

    // Per-stage registers: operand A, inverted-or-not operand B, partial sum
    // (slices resolved so far), carry into the next slice and valid.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              zero_q;
    logic              zero_d;

    // Inputs seen by each stage: stage 0 takes the ports, stage k the
    // registers of stage k-1.
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [BLOCK+1:0]  slice_r;
    logic              stall;

    // A result held at the output freezes the whole pipeline, bubbles included.
    assign stall    = v_q[LAST] && !out_ready;
    assign in_ready = !stall;

    // Subtraction is A + ~B + 1; the carry-in port is ignored in that mode.
    assign src_a[0] = data_operandA;
    assign src_b[0] = sub ? ~data_operandB : data_operandB;
    assign src_s[0] = '0;
    assign src_c[0] = sub ? 1'b1 : cin;
    assign src_v[0] = in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign src_a[k] = a_q[k-1];
        assign src_b[k] = b_q[k-1];
        assign src_s[k] = s_q[k-1];
        assign src_c[k] = c_q[k-1];
        assign src_v[k] = v_q[k-1];
    end

    always_comb begin
        slice_r = '0;
        ovf_d   = 1'b0;
        zero_d  = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            slice_r = cla_slice(src_a[k][k*BLOCK +: BLOCK],
                                src_b[k][k*BLOCK +: BLOCK],
                                src_c[k]);
            a_d[k] = src_a[k];
            b_d[k] = src_b[k];
            s_d[k] = src_s[k];
            s_d[k][k*BLOCK +: BLOCK] = slice_r[BLOCK-1:0];
            c_d[k] = slice_r[BLOCK+1];
            v_d[k] = src_v[k];
            // Flags are only meaningful once the top slice is resolved.
            if (k == LAST) begin
                ovf_d  = slice_r[BLOCK+1] ^ slice_r[BLOCK];
                zero_d = (s_d[k] == '0);
            end
        end
    end

    // ---- stage boundary: every stage register advances together ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
//
// Drives three instances of cla_pipe_adder (32/8, 8/8 and 16/4) from one
// directed sequence followed by a randomized phase. Expected results come
// from an arithmetic reference model that works on plain signed/unsigned
// integers.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

    localparam int NCFG = 3;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [31:0]     a_in   [NCFG];
    logic [31:0]     b_in   [NCFG];
    logic            sub_in [NCFG];
    logic            cin_in [NCFG];
    logic            iv     [NCFG];
    logic            ordy   [NCFG];
    logic [NCFG-1:0] ir;
    logic [NCFG-1:0] ov;
    logic [NCFG-1:0] co;
    logic [NCFG-1:0] of;
    logic [NCFG-1:0] zr;
    logic [31:0]     so     [NCFG];

    exp_t sb [NCFG][64];
    int   wr [NCFG];
    int   rd [NCFG];
    logic acc_last [NCFG];
    int   n_checks;
    int   n_pass;
    int   n_fail;
    logic log_on;
    int   log_n;
    int   log_s [16];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : 16;
        localparam int B = (g == 0) ? 8  : (g == 1) ? 8 : 4;
        logic [W-1:0] s;
        cla_pipe_adder #(.WIDTH(W), .BLOCK(B)) u_dut (
            .clock         (clock),
            .reset         (reset),
            .in_valid      (iv[g]),
            .in_ready      (ir[g]),
            .data_operandA (a_in[g][W-1:0]),
            .data_operandB (b_in[g][W-1:0]),
            .cin           (cin_in[g]),
            .sub           (sub_in[g]),
            .out_valid     (ov[g]),
            .out_ready     (ordy[g]),
            .sum           (s),
            .cout          (co[g]),
            .overflow      (of[g]),
            .zero          (zr[g])
        );
        assign so[g] = 32'(s);
    end

    function automatic int cfg_w(int g);
        return (g == 0) ? 32 : (g == 1) ? 8 : 16;
    endfunction

    function automatic int cfg_stg(int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : 4;
    endfunction

    // Reference: exact integer arithmetic, then reduce.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic sub, logic cin);
        exp_t   e;
        longint m, ua, ub, sa, sb_v, exact, ures;
        m     = longint'(1) << w;
        ua    = longint'(a) & (m - 1);
        ub    = longint'(b) & (m - 1);
        sa    = (ua >= m / 2) ? ua - m : ua;
        sb_v  = (ub >= m / 2) ? ub - m : ub;
        exact = sub ? sa - sb_v : sa + sb_v + longint'(cin);
        ures  = sub ? ua - ub : ua + ub + longint'(cin);
        e.v   = (exact >= m / 2) || (exact < -(m / 2));
        e.c   = sub ? (ua >= ub) : (ures >= m);
        e.s   = 32'(ures & (m - 1));
        e.z   = (e.s == 32'd0);
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Called just before each rising edge: records accepts into the
    // scoreboard and checks every result the consumer takes.
    task automatic monitor();
        exp_t e;
        for (int g = 0; g < NCFG; g++) begin
            acc_last[g] = 1'b0;
            if (reset) begin
                wr[g] = 0;
                rd[g] = 0;
            end else begin
                if (ov[g] && ordy[g]) begin
                    if (wr[g] == rd[g]) begin
                        chk($sformatf("c%0d_unexpected_result", g), 32'd1, 32'd0);
                    end else begin
                        e = sb[g][rd[g] % 64];
                        rd[g]++;
                        chk($sformatf("c%0d_sum", g), so[g], e.s);
                        chk($sformatf("c%0d_cout", g), 32'(co[g]), 32'(e.c));
                        chk($sformatf("c%0d_ovf", g), 32'(of[g]), 32'(e.v));
                        chk($sformatf("c%0d_zero", g), 32'(zr[g]), 32'(e.z));
                        if (g == 0 && log_on) begin
                            if (log_n < 16) log_s[log_n] = int'(so[0]);
                            log_n++;
                        end
                    end
                end
                if (iv[g] && ir[g]) begin
                    acc_last[g] = 1'b1;
                    sb[g][wr[g] % 64] = model(cfg_w(g), a_in[g], b_in[g], sub_in[g], cin_in[g]);
                    wr[g]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic directed(int g, string tag, logic [31:0] a, logic [31:0] b, logic s, logic c,
                            logic [31:0] es, logic ec, logic ev, logic ez);
        int lat;
        a_in[g]   = a;
        b_in[g]   = b;
        sub_in[g] = s;
        cin_in[g] = c;
        iv[g]     = 1'b1;
        ordy[g]   = 1'b1;
        step();
        iv[g] = 1'b0;
        chk({tag, "_accept"}, 32'(acc_last[g]), 32'd1);
        lat = 1;
        while (!ov[g] && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(cfg_stg(g)));
        chk({tag, "_sum"}, so[g], es);
        chk({tag, "_cout"}, 32'(co[g]), 32'(ec));
        chk({tag, "_ovf"}, 32'(of[g]), 32'(ev));
        chk({tag, "_zero"}, 32'(zr[g]), 32'(ez));
    endtask

    initial begin
        int          i;
        int          cyc;
        int          cnt;
        logic        stalled;
        logic [31:0] held;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        log_on   = 1'b0;
        log_n    = 0;
        reset    = 1'b1;
        for (int g = 0; g < NCFG; g++) begin
            a_in[g] = '0; b_in[g] = '0; sub_in[g] = 1'b0; cin_in[g] = 1'b0;
            iv[g] = 1'b0; ordy[g] = 1'b1; wr[g] = 0; rd[g] = 0; acc_last[g] = 1'b0;
        end

        step();
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("c%0d_rst_valid", g), 32'(ov[g]), 32'd0);
            chk($sformatf("c%0d_rst_sum", g), so[g], 32'd0);
            chk($sformatf("c%0d_rst_cout", g), 32'(co[g]), 32'd0);
            chk($sformatf("c%0d_rst_ovf", g), 32'(of[g]), 32'd0);
            chk($sformatf("c%0d_rst_zero", g), 32'(zr[g]), 32'd0);
            chk($sformatf("c%0d_rst_ready", g), 32'(ir[g]), 32'd1);
        end
        step();
        reset = 1'b0;

        directed(0, "add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        directed(0, "add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed(0, "add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed(0, "add_cin",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        directed(0, "sub_5_7",   32'd5,         32'd7,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed(0, "sub_min",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed(0, "sub_eq",    32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed(1, "w8_ovf",    32'h7F,        32'h01,        1'b0, 1'b0, 32'h80,        1'b0, 1'b1, 1'b0);
        directed(1, "w8_sub",    32'h00,        32'h01,        1'b1, 1'b0, 32'hFF,        1'b0, 1'b0, 1'b0);
        directed(2, "w16_wrap",  32'hFFFF,      32'h0001,      1'b0, 1'b0, 32'h0000,      1'b1, 1'b0, 1'b1);
        step();

        // Backpressure: stream i+i, stall three cycles once results appear.
        log_on  = 1'b1;
        log_n   = 0;
        i       = 0;
        cyc     = 0;
        stalled = 1'b0;
        while ((i < 10 || log_n < 10) && cyc < 100) begin
            if (i < 10) begin
                a_in[0] = 32'(i); b_in[0] = 32'(i); sub_in[0] = 1'b0; cin_in[0] = 1'b0; iv[0] = 1'b1;
            end else begin
                iv[0] = 1'b0;
            end
            step();
            cyc++;
            if (acc_last[0]) i++;
            if (ov[0] && !stalled) begin
                stalled = 1'b1;
                ordy[0] = 1'b0;
                held    = so[0];
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("bp_in_ready_low", 32'(ir[0]), 32'd0);
                    chk("bp_sum_held", so[0], held);
                    chk("bp_valid_held", 32'(ov[0]), 32'd1);
                end
                ordy[0] = 1'b1;
            end
        end
        iv[0]  = 1'b0;
        log_on = 1'b0;
        chk("bp_result_count", 32'(log_n), 32'd10);
        for (int j = 0; j < 10; j++) chk($sformatf("bp_order_%0d", j), 32'(log_s[j]), 32'(2 * j));

        // Reset mid-operation.
        for (int k = 0; k < 3; k++) begin
            a_in[0] = 32'(k + 3); b_in[0] = 32'd5; sub_in[0] = 1'b0; cin_in[0] = 1'b0; iv[0] = 1'b1;
            step();
        end
        iv[0] = 1'b0;
        step();
        chk("pre_rst_valid", 32'(ov[0]), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", 32'(ov[0]), 32'd0);
        chk("rst_async_sum", so[0], 32'd0);
        step();
        reset = 1'b0;
        directed(0, "post_rst", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ov[0]) cnt++;
        end
        chk("post_rst_extra_results", 32'(cnt), 32'd0);

        // Randomized traffic on all three configurations.
        for (int n = 0; n < 1500; n++) begin
            for (int g = 0; g < NCFG; g++) begin
                iv[g]     = ($urandom_range(0, 3) != 0);
                a_in[g]   = $urandom;
                b_in[g]   = $urandom;
                sub_in[g] = 1'($urandom_range(0, 1));
                cin_in[g] = 1'($urandom_range(0, 1));
                ordy[g]   = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        for (int g = 0; g < NCFG; g++) begin
            iv[g]   = 1'b0;
            ordy[g] = 1'b1;
        end
        for (int k = 0; k < 12; k++) step();
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("c%0d_drained", g), 32'(wr[g] - rd[g]), 32'd0);
            chk($sformatf("c%0d_idle_valid", g), 32'(ov[g]), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
